// File: rtl/sync_fifo_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo.
// The master drives the enables and write data. The slave (the FIFO) returns data, occupancy and status.
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_enable;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write_data, write_enable, read_enable,
        input  read_data, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  write_data, write_enable, read_enable,
        output read_data, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default is registered reads.
module sync_fifo #(
    parameter int DATA_WIDTH          = 8,
    parameter int DEPTH               = 8,
    parameter int ALMOST_FULL_THRESH  = 6,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic      clk,
    input  logic      rst,
    sync_fifo_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_TH    = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_TH    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic full_q, full_d, empty_q, empty_d;
    logic afull_q, afull_d, aempty_q, aempty_d;
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic wr_ok, rd_ok;

    // Acceptance uses only registered flags, so a full FIFO never passes a write through
    assign wr_ok = bus.write_enable && !full_q;
    assign rd_ok = bus.read_enable  && !empty_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_ok) wptr_d = wptr_q + 1'b1;
        if (rd_ok) rptr_d = rptr_q + 1'b1;
        if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
        else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
        // Flags are registered from the next count so they never glitch
        full_d   = (count_d == CNT_FULL);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AF_TH);
        aempty_d = (count_d <= AE_TH);
        ovf_d    = ovf_q | (bus.write_enable & full_q);
        unf_d    = unf_q | (bus.read_enable & empty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately not reset; the pointers make stale entries unreachable
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem_q[wptr_q] <= bus.write_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.read_data = empty_q ? '0 : mem_q[rptr_q];
`else
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst)        rdata_q <= '0;
        else if (rd_ok) rdata_q <= mem_q[rptr_q];
    end

    assign bus.read_data = rdata_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a queue model is checked every cycle, and literal expectations pin key points.
module tb_sync_fifo;
    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    sync_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .ALMOST_FULL_THRESH(AF), .ALMOST_EMPTY_THRESH(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;

    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_rd = '0;
    bit m_ov = 0, m_un = 0, started = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_rdata();
`ifdef SYNC_FIFO_FWFT_EN
        return (m_q.size() > 0) ? m_q[0] : '0;
`else
        return m_rd;
`endif
    endfunction

    // Queue model of one clock edge
    task automatic model_step(input bit r, input bit we, input logic [DW-1:0] wd, input bit re);
        int n = m_q.size();
        if (r) begin
            m_q.delete();
            m_ov = 0; m_un = 0; m_rd = '0; started = 1;
            return;
        end
        if (we && n == DEPTH) m_ov = 1;
        if (re && n == 0) m_un = 1;
        if (re && n > 0) m_rd = m_q.pop_front();
        if (we && n < DEPTH) m_q.push_back(wd);
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("count", 32'(bus.count), 32'(m_q.size()));
            check("empty", 32'(bus.empty), 32'(m_q.size() == 0));
            check("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
            check("almost_full", 32'(bus.almost_full), 32'(m_q.size() >= AF));
            check("almost_empty", 32'(bus.almost_empty), 32'(m_q.size() <= AE));
            check("overflow", 32'(bus.overflow), 32'(m_ov));
            check("underflow", 32'(bus.underflow), 32'(m_un));
            check("read_data", 32'(bus.read_data), 32'(exp_rdata()));
        end
    end

    task automatic cyc(input bit r, input bit we, input logic [DW-1:0] wd, input bit re);
        rst = r;
        bus.write_enable = we;
        bus.write_data = wd;
        bus.read_enable = re;
        @(posedge clk);
        model_step(r, we, wd, re);
        #1;
    endtask

    task automatic rd(input logic [DW-1:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
        check("lit_head", 32'(bus.read_data), 32'(exp));
        cyc(0, 0, '0, 1);
`else
        cyc(0, 0, '0, 1);
        check("lit_rdata", 32'(bus.read_data), 32'(exp));
`endif
    endtask

    initial begin
        // Reset with both enables high
        for (int i = 0; i < 3; i++) cyc(1, 1, 8'h55, 1);
        cyc(0, 0, '0, 0);
        check("lit_rst_count", 32'(bus.count), 0);
        check("lit_rst_empty", 32'(bus.empty), 1);
        check("lit_rst_aempty", 32'(bus.almost_empty), 1);
        check("lit_rst_full", 32'(bus.full), 0);
        check("lit_rst_ovf", 32'(bus.overflow), 0);
        check("lit_rst_unf", 32'(bus.underflow), 0);
        check("lit_rst_rdata", 32'(bus.read_data), 0);

        // Fill and overflow
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, DW'(i), 0);
            if (i == 5) check("lit_af_5", 32'(bus.almost_full), 0);
            if (i == 6) check("lit_af_6", 32'(bus.almost_full), 1);
            if (i == 7) check("lit_full_7", 32'(bus.full), 0);
            if (i == 8) check("lit_full_8", 32'(bus.full), 1);
        end
        cyc(0, 1, 8'h09, 0);
        check("lit_ovf_count", 32'(bus.count), 8);
        check("lit_ovf", 32'(bus.overflow), 1);

        // Drain and underflow
        for (int i = 1; i <= 8; i++) rd(DW'(i));
        check("lit_drain_empty", 32'(bus.empty), 1);
        cyc(0, 0, '0, 1);
        check("lit_unf", 32'(bus.underflow), 1);
`ifdef SYNC_FIFO_FWFT_EN
        check("lit_unf_rdata", 32'(bus.read_data), 0);
`else
        check("lit_unf_rdata", 32'(bus.read_data), 8'h08);
`endif

        // Wrap-around
        cyc(1, 0, '0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, DW'(8'h20 + i), 0);
        for (int i = 0; i < 5; i++) rd(DW'(8'h20 + i));
        for (int i = 0; i < 8; i++) cyc(0, 1, DW'(8'h10 + i), 0);
        check("lit_wrap_full", 32'(bus.full), 1);
        for (int i = 0; i < 8; i++) rd(DW'(8'h10 + i));
        check("lit_wrap_count", 32'(bus.count), 0);

        // Simultaneous access at count 4
        for (int i = 0; i < 4; i++) cyc(0, 1, DW'(8'h30 + i), 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, DW'(8'h40 + i), 1);
        check("lit_sim4_count", 32'(bus.count), 4);
        for (int i = 6; i < 10; i++) rd(DW'(8'h40 + i));

        // Simultaneous access at full
        cyc(1, 0, '0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, DW'(8'h50 + i), 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, DW'(8'h60 + i), 1);
        check("lit_simf_count", 32'(bus.count), 7);
        check("lit_simf_ovf", 32'(bus.overflow), 1);

        // Simultaneous access at empty
        cyc(1, 0, '0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, DW'(8'h70 + i), 1);
        check("lit_sime_count", 32'(bus.count), 1);
        check("lit_sime_unf", 32'(bus.underflow), 1);
        rd(8'h79);

        // Reset mid-operation
        cyc(1, 0, '0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, DW'(8'h80 + i), 0);
        cyc(1, 0, '0, 0);
        check("lit_mid_empty", 32'(bus.empty), 1);
        check("lit_mid_rdata", 32'(bus.read_data), 0);
        cyc(0, 1, 8'hAA, 0);
        rd(8'hAA);
        check("lit_mid_count", 32'(bus.count), 0);
        cyc(0, 0, '0, 0);
        cyc(0, 0, '0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised synchronous FIFO. It is the single-domain counterpart of the 8x8 CDC FIFO, generalised in data width and depth. It adds an occupancy count, programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, and an optional first-word-fall-through read mode. It sits wherever producer and consumer share one clock, for example between the packet parser and the egress arbiter.

## Interface
Parameters:
- DATA_WIDTH, 8: width of each stored word.
- DEPTH, 8: number of entries. Must be a power of two and at least 2.
- ALMOST_FULL_THRESH, 6: almost_full asserts when count >= this value. Legal range 1..DEPTH.
- ALMOST_EMPTY_THRESH, 2: almost_empty asserts when count <= this value. Legal range 0..DEPTH-1.
- ADDR_WIDTH (localparam): $clog2(DEPTH).

Ports:
- clk  input  1  sole clock; everything is sampled on the rising edge.
- rst  input  1  synchronous, active-high reset.
- write_data  input  DATA_WIDTH  word to enqueue.
- write_enable  input  1  write request.
- read_enable  input  1  read request (pop).
- read_data  output  DATA_WIDTH  dequeued word; in FWFT mode, the head word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= ALMOST_FULL_THRESH.
- almost_empty  output  1  count <= ALMOST_EMPTY_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; a write was attempted while full.
- underflow  output  1  sticky; a read was attempted while empty.

## Operation
- Storage:
  - DEPTH x DATA_WIDTH register array.
  - The array is not reset.
- Pointers:
  - Write and read pointers are ADDR_WIDTH bits wide.
  - They wrap naturally from DEPTH-1 to 0.
- Write acceptance:
  - wr_ok = write_enable && !full, using the registered full flag.
  - On wr_ok, write_data is stored at the write pointer and the write pointer increments.
- Read acceptance:
  - rd_ok = read_enable && !empty, using the registered empty flag.
  - On rd_ok, the read pointer increments.
- Count update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both or neither occur.
- Flags:
  - full, empty, almost_full and almost_empty are decoded from the count register.
  - They are glitch-free and never combinational from the inputs.
- Simultaneous read and write when 0 < count < DEPTH: both are accepted and count is unchanged.
- Write and read while full: the read is accepted and the write is rejected. overflow sets, count goes to DEPTH-1, and the write data is dropped. There is no pass-through.
- Write and read while empty: the write is accepted and the read is rejected. underflow sets and count goes to 1.
- overflow and underflow:
  - Set on the cycle of the offending request.
  - Held until rst.
  - Rejected requests never move the pointers or the count.
- Reset:
  - rst dominates the enables in the same cycle.
  - Pointers, count, overflow, underflow and read_data go to 0.
  - Reset values: empty = 1, full = 0, almost_empty = 1, almost_full = 0 (for the legal threshold ranges).
  - Asserting reset mid-operation discards all contents. Stale array data is never visible afterwards.

## Timing
- Standard mode (macro undefined):
  - read_data is a register loaded with the head word on the rd_ok edge, so it is valid one cycle after the edge where read_enable is sampled high.
  - read_data holds its value on any cycle without rd_ok, including rejected reads.
- Write-to-flag latency: a write at edge N is reflected in count, empty and full immediately after edge N.
- Write-to-first-read: the earliest read of a word written at edge N is sampled at edge N+1. Its data appears after edge N+1.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- SYNC_FIFO_FWFT_EN defined, first-word-fall-through mode:
  - read_data = array[read pointer] combinationally whenever !empty, and 0 while empty.
  - read_enable acknowledges and pops the presented word.
  - A word written at edge N is presented after edge N with zero read latency.
  - All acceptance, flag and error rules are unchanged.
- SYNC_FIFO_FWFT_EN undefined: standard registered-read mode as described under Timing.

## Test plan
- Reset:
  - Stimulus: hold rst for 3 cycles with write_enable = 1 and read_enable = 1.
  - Required: count = 0, empty = 1, almost_empty = 1, full = 0, overflow = 0, underflow = 0, read_data = 0.
- Fill and overflow (DEPTH = 8):
  - Stimulus: write 0x01..0x08 on consecutive cycles, then write 0x09.
  - Required: almost_full rises after the 6th write and full rises after the 8th. After the 9th attempt, count stays 8, overflow = 1 and 0x09 is dropped.
- Drain and underflow:
  - Stimulus: perform 8 reads, then a 9th read.
  - Required: read_data = 0x01..0x08 in order, and empty = 1 after the 8th read. On the 9th read, underflow = 1 and read_data holds 0x08 (standard mode) or shows 0 (FWFT).
- Wrap-around:
  - Stimulus: write 5, read 5, then write 0x10..0x17 (8 words) and read them back.
  - Required: data is returned in order and the pointers wrap cleanly.
- Simultaneous access:
  - Stimulus: at count = 4, assert write and read together for 10 cycles.
  - Required: count stays 4 and data stays in order.
  - Stimulus: same at full.
  - Required: count goes to 7 and overflow = 1.
  - Stimulus: same at empty.
  - Required: count goes to 1 and underflow = 1.
- Reset mid-operation:
  - Stimulus: with 5 entries stored, pulse rst for 1 cycle, then write 0xAA and read it.
  - Required: only 0xAA is returned, and no pre-reset data ever appears.
